// File: rtl/rob_ptr_ctrl.sv
// Reorder-buffer head/tail pointer control with wrap-bit full/empty detection.
// Optional ROB_ROLLBACK_EN: flush rolls tail back to a tag instead of emptying.
module rob_ptr_ctrl #(
  parameter int ROB_SIZE = 32,
  parameter int ALLOC_W  = 2,
  parameter int COMMIT_W = 2,
  localparam int AW = $clog2(ROB_SIZE),
  localparam int CW = AW + 1,
  localparam int NW = $clog2(ALLOC_W + 1),
  localparam int MW = $clog2(COMMIT_W + 1)
) (
  input  logic          clk_i,
  input  logic          reset_i,
  input  logic [NW-1:0] alloc_num_i,
  input  logic [MW-1:0] commit_num_i,
  input  logic          flush_i,
`ifdef ROB_ROLLBACK_EN
  input  logic [AW-1:0] flush_tag_i,
`endif
  output logic [AW-1:0] head_o,
  output logic [AW-1:0] tail_o,
  output logic [CW-1:0] count_o,
  output logic          empty_o,
  output logic          full_o,
  output logic          stall_o,
  output logic          err_o
);

  logic [CW-1:0] head_q, tail_q, head_d, tail_d;
  logic          err_q, err_d;
  logic [CW-1:0] count, free;
  logic [CW-1:0] alloc_ext, commit_ext, applied;
  logic          over;

  assign count      = tail_q - head_q;
  assign free       = CW'(ROB_SIZE) - count;
  assign alloc_ext  = CW'(alloc_num_i);
  assign commit_ext = CW'(commit_num_i);
  assign over       = commit_ext > count;
  assign applied    = over ? count : commit_ext;

  // Only registered occupancy counts; same-cycle commits free nothing.
  assign stall_o = !reset_i && !flush_i && (alloc_ext > free);

`ifdef ROB_ROLLBACK_EN
  logic [AW-1:0] off;
  logic          tag_ok;
  assign off    = flush_tag_i - head_q[AW-1:0];
  assign tag_ok = CW'(off) < count;
`endif

  always_comb begin
    head_d = head_q;
    tail_d = tail_q;
    err_d  = err_q;
    if (flush_i) begin
`ifdef ROB_ROLLBACK_EN
      // Adding from head picks the wrap bit for the survivor count.
      if (tag_ok) tail_d = head_q + CW'(off) + CW'(1);
      else        err_d  = 1'b1;
`else
      tail_d = head_q;
`endif
    end else begin
      if (!stall_o) tail_d = tail_q + alloc_ext;
      head_d = head_q + applied;
      if (over) err_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      head_q <= '0;
      tail_q <= '0;
      err_q  <= 1'b0;
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
      err_q  <= err_d;
    end
  end

  assign head_o  = head_q[AW-1:0];
  assign tail_o  = tail_q[AW-1:0];
  assign count_o = count;
  assign empty_o = count == '0;
  assign full_o  = count == CW'(ROB_SIZE);
  assign err_o   = err_q;

endmodule

// File: tb/tb_rob_ptr_ctrl.sv
// Directed bench for rob_ptr_ctrl with a free-running occupancy model.
// Model tracks total allocated/committed as unbounded integers.
module tb_rob_ptr_ctrl;
  localparam int S  = 8;
  localparam int AW = 3;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          reset_i = 1'b1;
  logic [1:0]    alloc_num_i = '0;
  logic [1:0]    commit_num_i = '0;
  logic          flush_i = 1'b0;
  logic [AW-1:0] flush_tag_i = '0;
  logic [AW-1:0] head_o, tail_o;
  logic [CW-1:0] count_o;
  logic          empty_o, full_o, stall_o, err_o;

  int nvec = 0;
  int nfail = 0;

  rob_ptr_ctrl #(.ROB_SIZE(S), .ALLOC_W(2), .COMMIT_W(2)) dut (
    .clk_i       (clk),
    .reset_i     (reset_i),
    .alloc_num_i (alloc_num_i),
    .commit_num_i(commit_num_i),
    .flush_i     (flush_i),
`ifdef ROB_ROLLBACK_EN
    .flush_tag_i (flush_tag_i),
`endif
    .head_o      (head_o),
    .tail_o      (tail_o),
    .count_o     (count_o),
    .empty_o     (empty_o),
    .full_o      (full_o),
    .stall_o     (stall_o),
    .err_o       (err_o)
  );

  always #5 clk = ~clk;

  int mh = 0, mt = 0;
  bit merr = 0;
  bit mvalid = 0;

  task automatic chk(string nm, logic [31:0] got, logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nfail++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, got, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    int cnt, off;
    cnt = mt - mh;
    if (reset_i) begin
      mh = 0; mt = 0; merr = 0; mvalid = 1;
    end else if (flush_i) begin
`ifdef ROB_ROLLBACK_EN
      off = (int'(flush_tag_i) - (mh % S) + S) % S;
      if (off < cnt) mt = mh + off + 1;
      else merr = 1;
`else
      off = 0;
      mt = mh + off;
`endif
    end else begin
      if (int'(alloc_num_i) <= S - cnt) mt += int'(alloc_num_i);
      if (int'(commit_num_i) > cnt) begin
        merr = 1; mh += cnt;
      end else mh += int'(commit_num_i);
    end
  end

  always @(negedge clk) begin
    int cnt;
    bit st;
    if (mvalid) begin
      cnt = mt - mh;
      st = !reset_i && !flush_i && (int'(alloc_num_i) > S - cnt);
      chk("m_head", 32'(head_o), 32'(mh % S));
      chk("m_tail", 32'(tail_o), 32'(mt % S));
      chk("m_count", 32'(count_o), 32'(cnt));
      chk("m_empty", 32'(empty_o), 32'(cnt == 0));
      chk("m_full", 32'(full_o), 32'(cnt == S));
      chk("m_stall", 32'(stall_o), 32'(st));
      chk("m_err", 32'(err_o), 32'(merr));
    end
  end

  task automatic drive(int a, int c, bit f, int tg, bit r);
    alloc_num_i  = 2'(a);
    commit_num_i = 2'(c);
    flush_i      = f;
    flush_tag_i  = AW'(tg);
    reset_i      = r;
    #2;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  int ta[16] = '{1,2,0,2,1,0,2,2,1,0,1,2,0,2,1,1};
  int tc[16] = '{0,1,2,0,2,1,2,0,0,2,1,1,2,0,2,0};
  int tf[16] = '{0,0,0,0,0,1,0,0,0,0,0,1,0,0,0,0};
  int tt[16] = '{0,0,0,0,0,2,0,0,0,0,0,6,0,0,0,0};

  initial begin
    drive(0, 0, 0, 0, 1);
    tick();
    tick();
    chk("rst_empty", 32'(empty_o), 1);
    chk("rst_tail", 32'(tail_o), 0);
    drive(2, 0, 0, 0, 0); tick(); chk("fill_t1", 32'(tail_o), 2);
    drive(2, 0, 0, 0, 0); tick(); chk("fill_t2", 32'(tail_o), 4);
    drive(2, 0, 0, 0, 0); tick(); chk("fill_t3", 32'(tail_o), 6);
    drive(2, 0, 0, 0, 0); tick(); chk("fill_t4", 32'(tail_o), 0);
    chk("fill_cnt", 32'(count_o), 8);
    chk("fill_full", 32'(full_o), 1);
    drive(1, 0, 0, 0, 0);
    chk("full_stall", 32'(stall_o), 1);
    tick(); chk("stall_tail", 32'(tail_o), 0);
    drive(2, 2, 0, 0, 0);
    chk("cm_stall", 32'(stall_o), 1);
    tick();
    chk("cm_head", 32'(head_o), 2);
    chk("cm_cnt", 32'(count_o), 6);
    drive(2, 0, 0, 0, 0); tick();
    chk("refill_tail", 32'(tail_o), 2);
    chk("refill_full", 32'(full_o), 1);
    for (int i = 0; i < 3; i++) begin
      drive(0, 2, 0, 0, 0); tick();
    end
    drive(0, 1, 0, 0, 0); tick();
    chk("one_cnt", 32'(count_o), 1);
    drive(0, 2, 0, 0, 0); tick();
    chk("ovr_head", 32'(head_o), 2);
    chk("ovr_empty", 32'(empty_o), 1);
    chk("ovr_err", 32'(err_o), 1);
    drive(0, 0, 0, 0, 0); tick();
    chk("err_sticky", 32'(err_o), 1);
    drive(0, 0, 0, 0, 1); tick();
    for (int i = 0; i < 4; i++) begin
      drive(2, 0, 0, 0, 0); tick();
    end
    drive(0, 2, 0, 0, 0); tick();
    drive(0, 1, 0, 0, 0); tick();
    chk("pre_fl_head", 32'(head_o), 3);
    chk("pre_fl_cnt", 32'(count_o), 5);
    drive(0, 0, 1, 4, 0);
    chk("fl_stall", 32'(stall_o), 0);
    tick();
`ifdef ROB_ROLLBACK_EN
    chk("fl_tail", 32'(tail_o), 5);
    chk("fl_cnt", 32'(count_o), 2);
`else
    chk("fl_tail", 32'(tail_o), 3);
    chk("fl_cnt", 32'(count_o), 0);
`endif
    drive(0, 2, 0, 0, 0); tick();
    drive(0, 2, 0, 0, 0); tick();
    chk("pre_rst_err", 32'(err_o), 1);
    drive(2, 0, 0, 0, 0); tick();
    drive(2, 1, 1, 0, 1);
    chk("all_stall", 32'(stall_o), 0);
    tick();
    chk("all_head", 32'(head_o), 0);
    chk("all_tail", 32'(tail_o), 0);
    chk("all_cnt", 32'(count_o), 0);
    chk("all_err", 32'(err_o), 0);
    drive(1, 0, 0, 0, 0); tick();
    chk("post_tail", 32'(tail_o), 1);
    for (int i = 0; i < 16; i++) begin
      drive(ta[i], tc[i], tf[i][0], tt[i], 0);
      tick();
    end
    drive(0, 0, 0, 0, 0);
    tick();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end
endmodule
